irs3_block_reader: RTL and testbench
====================================

IRS3_BLOCK_READER -- requirements
Module: irs3_block_reader

Interface
REQ-001 SHALL have parameter SETTLE, default 3: clk_i cycles between any irs_ch_o/irs_smp_o change and irs_dat_i capture; legal range 1-15.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  input  1  sole clock.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  read request, sampled in IDLE.
- block_i  input  9  IRS3 storage block to read, latched on accepted start_i.
- busy_o  output  1  high from accepted start_i until done_o.
- done_o  output  1  one-cycle pulse, readout complete.
- irs_rd_addr_rst_o  output  1  IRS3 RD_ADDR_RST.
- irs_rd_addr_adv_o  output  1  IRS3 RD_ADDR_ADV.
- irs_doe_o  output  1  IRS3 DOE.
- irs_smpall_o  output  1  IRS3 SMPALL, held 0.
- irs_ch_o  output  3  IRS3 CH.
- irs_smp_o  output  6  IRS3 SMP.
- irs_dat_i  input  12  IRS3 DAT.
- dat_o  output  16  {0, ch[2:0], sample[11:0]}.
- dat_valid_o  output  1  dat_o valid.
- dat_ready_i  input  1  downstream accept.

Function
REQ-003 States SHALL be IDLE, ARST, ADV_HI, ADV_LO, SETTLE, OUT, DONE.
REQ-004 IDLE: start_i=1 SHALL latch block_i, load advance counter = block_i, assert busy_o, and go to ARST next cycle; start_i outside IDLE SHALL be ignored.
REQ-005 ARST: irs_rd_addr_rst_o=1 for exactly one cycle; then ADV_HI if counter!=0, else SETTLE.
REQ-006 ADV_HI/ADV_LO: irs_rd_addr_adv_o=1 one cycle, 0 one cycle, counter decremented in ADV_LO; ADV_HI repeats while counter!=0, else SETTLE; exactly block_i pulses SHALL be issued.
REQ-007 irs_doe_o SHALL be 1 in SETTLE and OUT only.
REQ-008 Readout order: ch 0..7 outer, smp 0..63 inner; 512 words per request; irs_ch_o/irs_smp_o SHALL equal the current indices (0/0 on SETTLE entry).
REQ-009 SETTLE: count SETTLE cycles, then register irs_dat_i into dat_o, assert dat_valid_o, and go to OUT.
REQ-010 OUT: dat_o, dat_valid_o, irs_ch_o, irs_smp_o SHALL be held stable until dat_ready_i=1; on that cycle indices advance and next state is SETTLE, or DONE after ch=7/smp=63.
REQ-011 dat_valid_o SHALL never be high outside OUT; dat_ready_i outside OUT SHALL be ignored.
REQ-012 DONE: done_o=1 one cycle, busy_o cleared, return to IDLE; a start_i in DONE SHALL be ignored.
REQ-013 Minimum cycles start-to-done with dat_ready_i held 1: 2 + 2*block_i + 512*(SETTLE+1) + 1.

Reset
REQ-014 rst_i=1 SHALL force asynchronously: state IDLE, busy_o=0, done_o=0, dat_valid_o=0, dat_o=0, all irs_* outputs 0, counters 0.
REQ-015 Reset mid-readout SHALL abandon the request with no done_o; the next start_i SHALL begin a fresh readout from ARST.

Configuration
REQ-016 With IRS3_BLOCK_READER_TEST_PATTERN_EN defined, the captured sample SHALL be {block[5:0], smp[5:0]} instead of irs_dat_i, with all other timing unchanged; without it, irs_dat_i SHALL be captured.

Verification
REQ-017 block_i=0, ready=1, SETTLE=3: one RD_ADDR_RST pulse, no ADV pulses, 512 words, done_o at cycle 2051 after start.
REQ-018 block_i=5: exactly 5 ADV pulses, each 1 high/1 low cycle, before DOE rises.
REQ-019 dat_ready_i low 10 cycles on word ch=2/smp=17: dat_o=0x2xxx and SMP=17 held stable; the next word is smp=18.
REQ-020 DAT model returns ch*64+smp: word 200 = 0x30C8; last word = 0x71FF.
REQ-021 rst_i pulse at word 100: all outputs 0 immediately, no done_o; restart reads 512 words correctly.
REQ-022 With TEST_PATTERN_EN, block_i=0x47: first word 0x01C0, last word 0x71FF (ch=7, block[5:0]=0x07, smp=0x3F).

Source files
------------

// File: rtl/irs3_block_reader.sv
// IRS3 storage-block readout sequencer: address reset/advance, then 8x64 sample readout with handshake.
// Optional build macro IRS3_BLOCK_READER_TEST_PATTERN_EN replaces captured samples with {block[5:0], smp}.
`timescale 1ns/1ps
module irs3_block_reader #(
  parameter int SETTLE = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [8:0]  block_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        irs_rd_addr_rst_o,
  output logic        irs_rd_addr_adv_o,
  output logic        irs_doe_o,
  output logic        irs_smpall_o,
  output logic [2:0]  irs_ch_o,
  output logic [5:0]  irs_smp_o,
  input  logic [11:0] irs_dat_i,
  output logic [15:0] dat_o,
  output logic        dat_valid_o,
  input  logic        dat_ready_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARST   = 3'd1;
  localparam logic [2:0] S_ADV_HI = 3'd2;
  localparam logic [2:0] S_ADV_LO = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [8:0] IDX_LAST    = 9'd511;

  logic [2:0]  state;
  logic [8:0]  adv_cnt;
  logic [8:0]  idx;        // {ch[2:0], smp[5:0]}
  logic [3:0]  settle_cnt;
  logic [15:0] dat_p0;
  logic [11:0] capture;

`ifdef IRS3_BLOCK_READER_TEST_PATTERN_EN
  logic [5:0] pat_blk;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_blk <= '0;
    end else if (state == S_IDLE && start_i) begin
      pat_blk <= block_i[5:0];
    end
  end

  assign capture = {pat_blk, idx[5:0]};
`else
  assign capture = irs_dat_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      adv_cnt    <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      dat_p0     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            adv_cnt    <= block_i;
            idx        <= '0;
            settle_cnt <= '0;
            state      <= S_ARST;
          end
        end
        S_ARST: begin
          state <= (adv_cnt != '0) ? S_ADV_HI : S_SETTLE;
        end
        S_ADV_HI: begin
          state <= S_ADV_LO;
        end
        S_ADV_LO: begin
          // adv_cnt is at least 1 here; this pulse consumes it
          adv_cnt <= adv_cnt - 9'd1;
          state   <= (adv_cnt != 9'd1) ? S_ADV_HI : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            dat_p0     <= {1'b0, idx[8:6], capture};
            state      <= S_OUT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_OUT: begin
          if (dat_ready_i) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx   <= idx + 9'd1;
              state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o            = (state != S_IDLE) && (state != S_DONE);
  assign done_o            = (state == S_DONE);
  assign irs_rd_addr_rst_o = (state == S_ARST);
  assign irs_rd_addr_adv_o = (state == S_ADV_HI);
  assign irs_doe_o         = (state == S_SETTLE) || (state == S_OUT);
  assign irs_smpall_o      = 1'b0;
  assign irs_ch_o          = idx[8:6];
  assign irs_smp_o         = idx[5:0];
  assign dat_o             = dat_p0;
  assign dat_valid_o       = (state == S_OUT);

endmodule

// File: tb/tb_irs3_block_reader.sv
// Randomized bench for irs3_block_reader: IRS3 DAT model with settle tracking plus an ordered word queue.
`timescale 1ns/1ps
module tb_irs3_block_reader;

  localparam int SETTLE_P = 3;
`ifdef IRS3_BLOCK_READER_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [8:0]  block_i;
  logic        busy_o;
  logic        done_o;
  logic        irs_rd_addr_rst_o;
  logic        irs_rd_addr_adv_o;
  logic        irs_doe_o;
  logic        irs_smpall_o;
  logic [2:0]  irs_ch_o;
  logic [5:0]  irs_smp_o;
  logic [11:0] irs_dat_i;
  logic [15:0] dat_o;
  logic        dat_valid_o;
  logic        dat_ready_i;

  int checks = 0;
  int errors = 0;
  int age = 0;
  logic [9:0] prev_key = '0;

  irs3_block_reader #(.SETTLE(SETTLE_P)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .block_i(block_i),
    .busy_o(busy_o), .done_o(done_o),
    .irs_rd_addr_rst_o(irs_rd_addr_rst_o), .irs_rd_addr_adv_o(irs_rd_addr_adv_o),
    .irs_doe_o(irs_doe_o), .irs_smpall_o(irs_smpall_o),
    .irs_ch_o(irs_ch_o), .irs_smp_o(irs_smp_o), .irs_dat_i(irs_dat_i),
    .dat_o(dat_o), .dat_valid_o(dat_valid_o), .dat_ready_i(dat_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [8:0] b, input int c, input int s);
    logic [2:0]  c3;
    logic [5:0]  s6;
    logic [11:0] smpl;
    c3 = c[2:0];
    s6 = s[5:0];
    smpl = TP ? {b[5:0], s6} : 12'(c * 64 + s);
    return {1'b0, c3, smpl};
  endfunction

  function automatic logic [31:0] all_outs();
    return {busy_o, done_o, dat_valid_o, dat_o, irs_rd_addr_rst_o, irs_rd_addr_adv_o,
            irs_doe_o, irs_smpall_o, irs_ch_o, irs_smp_o};
  endfunction

  // IRS3 stand-in: DAT is only correct once CH/SMP/DOE have been steady SETTLE_P cycles
  task automatic drive_dat();
    logic [9:0]  key;
    logic [11:0] good;
    key  = {irs_doe_o, irs_ch_o, irs_smp_o};
    good = 12'(int'(irs_ch_o) * 64 + int'(irs_smp_o));
    if (key != prev_key) begin
      age = 1;
      prev_key = key;
    end else if (age < 1000) begin
      age++;
    end
    irs_dat_i = (irs_doe_o && age >= SETTLE_P) ? good : ~good;
  endtask

  // mode 0: ready held 1; mode 1: random ready + stray starts; mode 2: 10-cycle stall on ch2/smp17
  task automatic run_req(input logic [8:0] blk, input int mode, input int rst_word);
    logic [15:0] expq[$];
    logic [15:0] e, held_word;
    logic [5:0]  held_smp;
    logic [2:0]  held_ch;
    logic        prev_adv, held_v, finished;
    int n, words, adv_pulses, rst_pulses, stall, budget, dn, min_cyc;
    for (int c = 0; c < 8; c++)
      for (int s = 0; s < 64; s++)
        expq.push_back(exp_word(blk, c, s));
    min_cyc = 2 + 2 * int'(blk) + 512 * (SETTLE_P + 1) + 1;
    budget = min_cyc * ((mode == 1) ? 4 : 1) + 200;
    n = 0; words = 0; adv_pulses = 0; rst_pulses = 0; stall = 0;
    prev_adv = 1'b0; held_v = 1'b0; finished = 1'b0;
    held_word = '0; held_smp = '0; held_ch = '0;

    @(negedge clk_i);
    block_i = blk;
    start_i = 1'b1;
    while (!finished && n < budget) begin
      @(negedge clk_i);
      n++;
      if (n == 1) begin
        start_i = 1'b0;
        block_i = 9'($urandom);
        chk("busy_on", {31'd0, busy_o}, 32'd1);
      end else if (mode == 1) begin
        start_i = ($urandom % 8) == 0;
        block_i = 9'($urandom);
      end
      drive_dat();
      if (irs_rd_addr_rst_o) rst_pulses++;
      if (irs_rd_addr_adv_o) begin
        adv_pulses++;
        chk("adv_gap", {31'd0, prev_adv}, 32'd0);
        chk("adv_doe", {31'd0, irs_doe_o}, 32'd0);
      end
      prev_adv = irs_rd_addr_adv_o;
      if (dat_valid_o) chk("valid_doe", {31'd0, irs_doe_o}, 32'd1);
      if (held_v) begin
        chk("hold_valid", {31'd0, dat_valid_o}, 32'd1);
        chk("hold_dat", {16'd0, dat_o}, {16'd0, held_word});
        chk("hold_idx", {23'd0, irs_ch_o, irs_smp_o}, {23'd0, held_ch, held_smp});
      end
      if (rst_word >= 0 && dat_valid_o && words == rst_word) begin
        rst_i = 1'b1;
        #1;
        chk("midrst_outs", all_outs(), 32'd0);
        finished = 1'b1;
      end else begin
        case (mode)
          0: dat_ready_i = 1'b1;
          1: dat_ready_i = ($urandom % 3) != 0;
          default: begin
            if (dat_valid_o && words == 2 * 64 + 17 && stall < 10) begin
              dat_ready_i = 1'b0;
              stall++;
            end else begin
              dat_ready_i = 1'b1;
            end
          end
        endcase
        if (dat_valid_o && dat_ready_i) begin
          chk("idx", {23'd0, irs_ch_o, irs_smp_o}, 32'(words));
          if (expq.size() == 0) begin
            chk("extra_word", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("word", {16'd0, dat_o}, {16'd0, e});
          end
          if (!TP && words == 200) chk("word200", {16'd0, dat_o}, 32'h30C8);
          if (!TP && words == 511) chk("word_last", {16'd0, dat_o}, 32'h71FF);
          if (TP && blk == 9'h047 && words == 0) chk("tp_first", {16'd0, dat_o}, 32'h01C0);
          if (TP && blk == 9'h047 && words == 511) chk("tp_last", {16'd0, dat_o}, 32'h71FF);
          words++;
        end
        held_v = dat_valid_o && !dat_ready_i;
        held_word = dat_o;
        held_smp = irs_smp_o;
        held_ch = irs_ch_o;
        if (done_o) begin
          // the cycle in which start_i was presented counts as cycle 1
          if (mode == 0) chk("done_cycle", 32'(n + 1), 32'(min_cyc));
          if (mode == 2) chk("done_cycle_stall", 32'(n + 1), 32'(min_cyc + 10));
          start_i = 1'b1;
          block_i = 9'($urandom);
          finished = 1'b1;
        end
      end
    end

    if (!finished) begin
      chk("timeout", 32'd0, 32'd1);
      start_i = 1'b0;
    end else if (rst_i) begin
      repeat (2) @(negedge clk_i);
      chk("rst_hold_outs", all_outs(), 32'd0);
      rst_i = 1'b0;
      dat_ready_i = 1'b1;
      start_i = 1'b0;
      dn = 0;
      repeat (30) begin
        @(negedge clk_i);
        drive_dat();
        if (done_o || busy_o) dn++;
      end
      chk("no_done_after_rst", 32'(dn), 32'd0);
    end else begin
      @(negedge clk_i);
      start_i = 1'b0;
      drive_dat();
      chk("done_pulse", {31'd0, done_o}, 32'd0);
      chk("busy_off", {31'd0, busy_o}, 32'd0);
      chk("words", 32'(words), 32'd512);
      chk("adv_pulses", 32'(adv_pulses), {23'd0, blk});
      chk("arst_pulses", 32'(rst_pulses), 32'd1);
      chk("smpall", {31'd0, irs_smpall_o}, 32'd0);
      if (mode == 2) chk("stall_len", 32'(stall), 32'd10);
      repeat (3) begin
        @(negedge clk_i);
        drive_dat();
      end
      chk("stays_idle", {31'd0, busy_o}, 32'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    block_i = '0;
    dat_ready_i = 1'b0;
    irs_dat_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_outs", all_outs(), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_outs", all_outs(), 32'd0);

    run_req(9'd0, 0, -1);
    run_req(9'd5, 0, -1);
    run_req(9'h047, 1, -1);
    run_req(9'($urandom_range(1, 20)), 2, -1);
    run_req(9'd3, 1, 100);
    run_req(9'($urandom_range(0, 30)), 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
